// File: rtl/uart_file_xfer_engine.sv
// UART file-transfer engine: watches the UART byte stream for 0x02 (send file),
// 0x03 (receive file) and 0x04 (finish), and moves file bytes between the UART
// and a memory master port. A 4-byte little-endian size header precedes each file.
// Every other byte seen while idle is passed through on con_data/con_valid.
// Optional: define UART_XFER_PROGRESS_EN to add progress/progress_valid milestone
// strobes (0, 10, ..., 100 percent).
module uart_file_xfer_engine #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned MAX_BYTES = 2**20,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          con_data,
  output logic                con_valid,
  input  logic [ADDR_W-1:0]   send_base,
  input  logic [31:0]         send_size,
  input  logic [ADDR_W-1:0]   recv_base,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         recv_len,
  output logic                overflow
`ifdef UART_XFER_PROGRESS_EN
  ,
  output logic [6:0]          progress,
  output logic                progress_valid
`endif
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    StIdle, StTxSize, StTxRd, StTxData, StRxSize, StRxData, StRxWr, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;     // word-aligned address of current word
  logic [LW-1:0]       lane_q, lane_d;       // byte lane within the current word
  logic [31:0]         size_q, size_d;
  logic [31:0]         cnt_q, cnt_d;         // file bytes transferred so far
  logic [1:0]          hdr_q, hdr_d;         // size-header byte index
  logic [DATA_W-1:0]   word_q, word_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         recv_len_q, recv_len_d;

  logic                rx_ready_q, rx_ready_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                con_valid_q, con_valid_d;
  logic [7:0]          con_data_q, con_data_d;
  logic                mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]       mem_wstrb_q, mem_wstrb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic rx_fire, tx_fire, mem_fire;
  assign rx_fire  = rx_valid & rx_ready_q;
  assign tx_fire  = tx_valid_q & tx_ready;
  assign mem_fire = mem_valid_q & mem_ready;

  // Bit position (in bytes) of a byte lane inside the memory word.
  function automatic int unsigned pos_of(input logic [LW-1:0] l);
    return MSB_FIRST ? (NB - 1 - 32'(l)) : 32'(l);
  endfunction

  function automatic logic [LW-1:0] lane_of(input logic [ADDR_W-1:0] a);
    return LW'(a % ADDR_W'(NB));
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    lane_d     = lane_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    word_d     = word_q;
    strb_d     = strb_q;
    ovf_d      = ovf_q;
    recv_len_d = recv_len_q;
    unique case (state_q)
      StIdle: begin
        if (rx_fire) begin
          case (rx_data)
            8'h02: begin
              state_d = StTxSize;
              lane_d  = lane_of(send_base);
              waddr_d = send_base - ADDR_W'(lane_of(send_base));
              size_d  = send_size;
              hdr_d   = '0;
              cnt_d   = '0;
            end
            8'h03: begin
              state_d = StRxSize;
              lane_d  = lane_of(recv_base);
              waddr_d = recv_base - ADDR_W'(lane_of(recv_base));
              size_d  = '0;
              hdr_d   = '0;
              cnt_d   = '0;
              word_d  = '0;
              strb_d  = '0;
              ovf_d   = 1'b0;
            end
            8'h04:   state_d = StDone;
            default: ;
          endcase
        end
      end
      StTxSize: begin
        if (tx_fire) begin
          hdr_d = hdr_q + 2'd1;
          if (hdr_q == 2'd3) state_d = (size_q == '0) ? StIdle : StTxRd;
        end
      end
      StTxRd: begin
        if (mem_fire) begin
          word_d  = mem_rdata;
          state_d = StTxData;
        end
      end
      StTxData: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d == size_q) begin
            state_d = StIdle;
          end else if (lane_q == LW'(NB - 1)) begin
            lane_d  = '0;
            waddr_d = waddr_q + ADDR_W'(NB);
            state_d = StTxRd;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      StRxSize: begin
        if (rx_fire) begin
          size_d[8*hdr_q +: 8] = rx_data;
          hdr_d = hdr_q + 2'd1;
          if (hdr_q == 2'd3) begin
            if (size_d == '0) begin
              state_d    = StIdle;
              recv_len_d = '0;
            end else begin
              state_d = StRxData;
            end
          end
        end
      end
      StRxData: begin
        if (rx_fire) begin
          cnt_d = cnt_q + 32'd1;
          // Bytes beyond capacity are consumed but never stored.
          if (cnt_q < MAX_BYTES) begin
            word_d[8*pos_of(lane_q) +: 8] = rx_data;
            strb_d[pos_of(lane_q)]        = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (cnt_d == size_q || lane_q == LW'(NB - 1)) state_d = StRxWr;
          else                                          lane_d  = lane_q + 1'b1;
        end
      end
      StRxWr: begin
        // An empty word (overflow region) completes without a memory request.
        if (mem_fire || strb_q == '0) begin
          word_d  = '0;
          strb_d  = '0;
          lane_d  = '0;
          waddr_d = waddr_q + ADDR_W'(NB);
          if (cnt_q == size_q) begin
            state_d    = StIdle;
            recv_len_d = (size_q > MAX_BYTES) ? 32'(MAX_BYTES) : size_q;
          end else begin
            state_d = StRxData;
          end
        end
      end
      StDone:  ;
      default: state_d = StIdle;
    endcase
  end

  // Output next values, decoded from the upcoming state so outputs can be registered.
  always_comb begin
    rx_ready_d  = state_d inside {StIdle, StRxSize, StRxData, StDone};
    tx_valid_d  = state_d inside {StTxSize, StTxData};
    tx_data_d   = '0;
    if (state_d == StTxSize)      tx_data_d = size_d[8*hdr_d +: 8];
    else if (state_d == StTxData) tx_data_d = word_d[8*pos_of(lane_d) +: 8];
    con_valid_d = (state_q == StIdle) && rx_fire && !(rx_data inside {8'h02, 8'h03, 8'h04});
    con_data_d  = con_valid_d ? rx_data : con_data_q;
    mem_valid_d = (state_d == StTxRd) || ((state_d == StRxWr) && (strb_d != '0));
    mem_wdata_d = (state_d == StRxWr) ? word_d : '0;
    mem_wstrb_d = (state_d == StRxWr) ? strb_d : '0;
    busy_d      = !(state_d inside {StIdle, StDone});
    done_d      = (state_d == StDone);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q     <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      word_q      <= '0;
      strb_q      <= '0;
      ovf_q       <= 1'b0;
      recv_len_q  <= '0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      word_q      <= word_d;
      strb_q      <= strb_d;
      ovf_q       <= ovf_d;
      recv_len_q  <= recv_len_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      mem_valid_q <= mem_valid_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign recv_len  = recv_len_q;
  assign overflow  = ovf_q;

`ifdef UART_XFER_PROGRESS_EN
  logic [3:0]  ms_q;         // next milestone, in tens of percent
  logic        prog_act_q;
  logic [6:0]  prog_q;
  logic        prog_v_q;
  logic [35:0] thr;
  logic        prog_start;

  assign thr        = (36'(size_q) * 36'(ms_q)) / 36'd10;
  assign prog_start = (state_q inside {StTxSize, StRxSize}) && (state_d != state_q);

  // Milestone tracker: one strobe per cycle, catching up when milestones share an index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_q       <= '0;
      prog_act_q <= 1'b0;
      prog_q     <= '0;
      prog_v_q   <= 1'b0;
    end else begin
      prog_v_q <= 1'b0;
      if (prog_start) begin
        prog_act_q <= 1'b1;
        ms_q       <= (size_d == '0) ? 4'd10 : 4'd0;
      end else if (prog_act_q && (36'(cnt_q) >= thr)) begin
        prog_v_q <= 1'b1;
        prog_q   <= 7'(ms_q) * 7'd10;
        ms_q     <= ms_q + 4'd1;
        if (ms_q == 4'd10) prog_act_q <= 1'b0;
      end
    end
  end

  assign progress       = prog_q;
  assign progress_valid = prog_v_q;
`endif

endmodule

// File: doc/uart_file_xfer_engine.md
Name: uart_file_xfer_engine

Overview:
- Hardware replacement for the console-side file-transfer protocol: parses a UART byte stream for control codes 0x02 (send file), 0x03 (receive file) and 0x04 (finish).
- Streams file contents between the UART byte channels and a native-memory master port, using a 4-byte little-endian size header.
- Sits between the UART byte FIFOs and system/DDR memory, so a host CPU is not needed for bulk program or result transfer.
- Generalised in word width, byte order, address width and size limit.

Parameters:
- DATA_W, 32, memory word width; multiple of 8, range 8..128.
- ADDR_W, 24, memory byte-address width.
- MAX_BYTES, 2**20, receive capacity in bytes; excess bytes are discarded.
- MSB_FIRST, 0, 0 = byte 0 of a word is bits [7:0]; 1 = byte 0 is bits [DATA_W-1:DATA_W-8].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte consumed when rx_valid&rx_ready
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held stable until tx_ready
- tx_ready  in  1  UART can accept a byte
- con_data  out  8  pass-through console character
- con_valid  out  1  one-cycle strobe per console character
- send_base  in  ADDR_W  byte address of the file to send; sampled on 0x02
- send_size  in  32  byte count to send; sampled on 0x02
- recv_base  in  ADDR_W  byte address for the received file; sampled on 0x03
- mem_valid  out  1  memory request
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_wdata  out  DATA_W  write data
- mem_wstrb  out  DATA_W/8  byte strobes; 0 = read
- mem_rdata  in  DATA_W  read data
- mem_ready  in  1  request completes
- busy  out  1  high outside IDLE/DONE
- done  out  1  sticky after 0x04
- recv_len  out  32  bytes written by the last receive
- overflow  out  1  last receive exceeded MAX_BYTES

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. Reset mid-transfer aborts immediately; no memory request is left asserted.
- All outputs are registered.
- States: IDLE, TX_SIZE, TX_RD, TX_DATA, RX_SIZE, RX_DATA, RX_WR, DONE.
- IDLE:
  - rx_ready=1.
  - 0x02 -> TX_SIZE; latch send_base and send_size.
  - 0x03 -> RX_SIZE.
  - 0x04 -> DONE.
  - Any other byte -> con_data=byte, con_valid=1 on the next cycle.
- TX_SIZE: sends the 4 size bytes LSB first, each held until tx_ready. Then:
  - size 0 -> IDLE;
  - otherwise -> TX_RD.
- TX_RD: mem_valid=1, mem_wstrb=0. On mem_ready, capture mem_rdata -> TX_DATA.
- TX_DATA:
  - Sends bytes of the captured word in MSB_FIRST order.
  - The final partial word sends only the remaining bytes.
  - Word exhausted -> TX_RD with address += DATA_W/8.
  - Last byte accepted -> IDLE.
- RX_SIZE: accepts 4 bytes LSB first into the size register.
  - Size 0 -> IDLE with recv_len=0.
  - Otherwise -> RX_DATA.
- RX_DATA:
  - Packs bytes into a word buffer and sets the matching strobe bit.
  - On a full word or the final byte -> RX_WR.
  - Bytes at offset >= MAX_BYTES are consumed but not stored; overflow is set.
- RX_WR:
  - mem_valid=1 with accumulated strobes; rx_ready=0.
  - On mem_ready: clear buffer and strobes; advance address.
  - Go to RX_DATA, or to IDLE after the last byte, with recv_len=min(size,MAX_BYTES).
  - A word with all strobes 0 (overflow region) skips the memory request.
- DONE: done=1; rx_ready=1; all bytes are ignored; left only by reset.
- Handshakes:
  - mem_valid rises at most once per word and holds until mem_ready.
  - mem_ready in the same cycle that mem_valid asserts is legal.
- Addresses wrap modulo 2**ADDR_W.
- A misaligned base uses byte lanes starting at base%(DATA_W/8); the first word is partial.
- Latency: one IDLE byte -> con_valid after 1 cycle; the first TX byte is valid 1 cycle after the 0x02 handshake.

Optional Feature:
- UART_XFER_PROGRESS_EN defined:
  - Adds output progress[6:0] and strobe progress_valid.
  - Milestones k=0,10,...,100 percent, at byte index i == size*k/100 (integer math).
  - One strobe per milestone per transfer in both directions; 100 is strobed at completion.
  - Size 0 strobes only 100.
- Not defined: ports absent, no divider logic.

Test Plan:
- Bytes "Hi\n" in IDLE -> con_valid pulses with 0x48, 0x69, 0x0A; no memory traffic.
- 0x02, send_base=0x100, send_size=6, DATA_W=32, MSB_FIRST=0, mem words 0x44332211, 0x88776655 -> tx 06 00 00 00 11 22 33 44 55 66; two reads at 0x100 and 0x104.
- 0x03, size 5, bytes AA BB CC DD EE, recv_base=0x200 -> write 0xDDCCBBAA strb 0xF @0x200; write 0x000000EE strb 0x1 @0x204; recv_len=5.
- MAX_BYTES=4, receive size 6 -> one write; overflow=1; recv_len=4; all 6 bytes consumed.
- tx_ready held low 20 cycles mid-send, then reset asserted -> tx_data stable while stalled; after reset all outputs 0, state IDLE; 0x04 -> done=1.
- UART_XFER_PROGRESS_EN, send size 20 -> progress strobes 0, 10, …, 100, eleven total.
